int_scheduler: RTL and testbench

- Priority scheduler in front of the CPU interrupt entry: latches 16 interrupt source events as pending bits, applies a software mask, and picks one winner by fixed priority.
- Presents the winner to the core with an ACK / end-of-interrupt (EOI) handshake and tracks the interrupt in service.
- Sits between the interrupt trigger sources (external, DMA, stack faults, reset, software, IRQ) and the core sequencer.

---
 rtl/int_scheduler.sv | 149 ++++++++++++++
 tb/tb_int_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/int_scheduler.sv
// Fixed-priority interrupt scheduler: edge-detected pending bits, software mask,
// NMI override, and an ACK/EOI handshake. Define INT_SCHED_NEST_EN for nested preemption.
module int_scheduler #(
    parameter int          NSRC       = 16,
    parameter int          NMI_ID     = 8,
    parameter logic [15:0] MASK_RST   = 16'hFFFF,
    parameter int          NEST_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NSRC-1:0] SRC_TRIG,
    input  logic            MASK_WE,
    input  logic [NSRC-1:0] MASK_WDATA,
    output logic [NSRC-1:0] MASK,
    output logic [NSRC-1:0] PEND,
    output logic [3:0]      NEXT_ID,
    output logic            NEXT_ON,
    output logic            IRQ,
    input  logic            ACK,
    input  logic            EOI,
    output logic [3:0]      ACTIVE_ID,
    output logic            IN_SERVICE
);

    localparam logic [3:0] NMI = 4'(NMI_ID);

    typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

    state_t          state_q;
    logic [NSRC-1:0] hist_q, pend_q, pend_d, mask_q;
    logic [NSRC-1:0] rise, elig, ack_clr;
    logic [3:0]      next_id_q, active_id_q, win;
    logic            next_on_q, in_service_q;

    assign rise = SRC_TRIG & ~hist_q;
    assign elig = pend_q & (mask_q | (NSRC'(1) << NMI));

    // NMI beats everything; otherwise the lowest eligible ID wins.
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) win = i[3:0];
        end
        if (elig[NMI]) win = NMI;
    end

    // A rise landing on the bit being acknowledged is a new event and survives the clear.
    always_comb begin
        ack_clr = '0;
        if (state_q == PRESENT && ACK) ack_clr[next_id_q] = 1'b1;
        pend_d = (pend_q & ~ack_clr) | rise;
    end

`ifdef INT_SCHED_NEST_EN
    localparam int SPW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [3:0]     stk_q [NEST_DEPTH];
    logic [SPW-1:0] sp_q;
    logic           preempt;

    function automatic logic beats(input logic [3:0] a, input logic [3:0] b);
        if (a == NMI) return (b != NMI);
        return (b != NMI) && (a < b);
    endfunction

    assign preempt = (|elig) && beats(win, active_id_q) &&
                     (int'(sp_q) < NEST_DEPTH - 1);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            hist_q       <= '0;
            pend_q       <= '0;
            mask_q       <= MASK_RST;
            next_id_q    <= '0;
            next_on_q    <= 1'b0;
            active_id_q  <= '0;
            in_service_q <= 1'b0;
`ifdef INT_SCHED_NEST_EN
            sp_q <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= '0;
`endif
        end else begin
            hist_q <= SRC_TRIG;
            pend_q <= pend_d;
            if (MASK_WE) mask_q <= MASK_WDATA;
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        next_id_q <= win;
                        next_on_q <= 1'b1;
                        state_q   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ACK) begin
`ifdef INT_SCHED_NEST_EN
                        if (in_service_q) begin
                            stk_q[sp_q] <= active_id_q;
                            sp_q        <= sp_q + 1'b1;
                        end
`endif
                        active_id_q  <= next_id_q;
                        in_service_q <= 1'b1;
                        next_on_q    <= 1'b0;
                        next_id_q    <= '0;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (EOI) begin
`ifdef INT_SCHED_NEST_EN
                        if (sp_q != '0) begin
                            active_id_q <= stk_q[sp_q - 1'b1];
                            sp_q        <= sp_q - 1'b1;
                        end else begin
                            in_service_q <= 1'b0;
                            active_id_q  <= '0;
                            state_q      <= IDLE;
                        end
`else
                        in_service_q <= 1'b0;
                        active_id_q  <= '0;
                        state_q      <= IDLE;
`endif
                    end
`ifdef INT_SCHED_NEST_EN
                    else if (preempt) begin
                        next_id_q <= win;
                        next_on_q <= 1'b1;
                        state_q   <= PRESENT;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MASK       = mask_q;
    assign PEND       = pend_q;
    assign NEXT_ID    = next_id_q;
    assign NEXT_ON    = next_on_q;
    assign IRQ        = next_on_q;
    assign ACTIVE_ID  = active_id_q;
    assign IN_SERVICE = in_service_q;

endmodule

// File: tb/tb_int_scheduler.sv
// Scoreboard bench for int_scheduler: a behavioural model predicts every cycle's
// outputs into a queue, and an independent monitor pops and compares them.
module tb_int_scheduler;

    localparam int NEST_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST, MASK_WE, ACK, EOI;
    logic [15:0] SRC_TRIG, MASK_WDATA, MASK, PEND;
    logic [3:0]  NEXT_ID, ACTIVE_ID;
    logic        NEXT_ON, IRQ, IN_SERVICE;

    int_scheduler #(.NSRC(16), .NMI_ID(8), .MASK_RST(16'hFFFF), .NEST_DEPTH(NEST_DEPTH)) dut (
        .CLK(CLK), .RST(RST), .SRC_TRIG(SRC_TRIG), .MASK_WE(MASK_WE), .MASK_WDATA(MASK_WDATA),
        .MASK(MASK), .PEND(PEND), .NEXT_ID(NEXT_ID), .NEXT_ON(NEXT_ON), .IRQ(IRQ),
        .ACK(ACK), .EOI(EOI), .ACTIVE_ID(ACTIVE_ID), .IN_SERVICE(IN_SERVICE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pend, mask;
        logic [3:0]  nid, aid;
        logic        on, irq, ins;
    } snap_t;

    snap_t expq[$];
    int checks = 0, failures = 0;

    // Reference model: abstract scheduler state in plain variables.
    typedef enum int {M_IDLE, M_PRESENT, M_SERVICE} mmode_t;
    mmode_t      m_mode;
    logic [15:0] m_pend, m_mask, m_hist;
    int          m_next, m_active;
    logic        m_on, m_insvc;
    int          m_stack[$];

    function automatic int rank(input int id);
        return (id == 8) ? -1 : id;
    endfunction

    function automatic int pick(input logic [15:0] e);
        int best = -1;
        for (int i = 0; i < 16; i++)
            if (e[i] && (best < 0 || rank(i) < rank(best))) best = i;
        return best;
    endfunction

    task automatic model_step(input logic r, input logic [15:0] t, input logic mw,
                              input logic [15:0] md, input logic a, input logic e);
        logic [15:0] rise, eligv, newp;
        int w;
        if (r) begin
            m_mode = M_IDLE; m_pend = 0; m_mask = 16'hFFFF; m_hist = 0;
            m_next = 0; m_active = 0; m_on = 0; m_insvc = 0; m_stack.delete();
            return;
        end
        rise   = t & ~m_hist;
        m_hist = t;
        eligv  = m_pend & (m_mask | 16'h0100);
        w      = pick(eligv);
        newp   = m_pend | rise;
        case (m_mode)
            M_IDLE: if (w >= 0) begin m_next = w; m_on = 1; m_mode = M_PRESENT; end
            M_PRESENT: if (a) begin
                if (!rise[m_next]) newp[m_next] = 1'b0;
                if (m_insvc) m_stack.push_back(m_active);
                m_active = m_next; m_insvc = 1; m_on = 0; m_next = 0; m_mode = M_SERVICE;
            end
            M_SERVICE: begin
                if (e) begin
                    if (m_stack.size() > 0) m_active = m_stack.pop_back();
                    else begin m_insvc = 0; m_active = 0; m_mode = M_IDLE; end
                end
`ifdef INT_SCHED_NEST_EN
                else if (w >= 0 && rank(w) < rank(m_active) && m_stack.size() < NEST_DEPTH - 1) begin
                    m_next = w; m_on = 1; m_mode = M_PRESENT;
                end
`endif
            end
            default: ;
        endcase
        m_pend = newp;
        if (mw) m_mask = md;
    endtask

    task automatic step(input logic r, input logic [15:0] t, input logic mw,
                        input logic [15:0] md, input logic a, input logic e);
        snap_t s;
        @(negedge CLK);
        RST = r; SRC_TRIG = t; MASK_WE = mw; MASK_WDATA = md; ACK = a; EOI = e;
        model_step(r, t, mw, md, a, e);
        s.pend = m_pend; s.mask = m_mask; s.nid = 4'(m_next); s.aid = 4'(m_active);
        s.on = m_on; s.irq = m_on; s.ins = m_insvc;
        expq.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0, 0, 0);
    endtask

    // Acknowledge whatever is presented and retire whatever is in service.
    task automatic serve(input int n);
        for (int i = 0; i < n; i++)
            step(0, 16'h0, 0, 16'h0, m_mode == M_PRESENT, m_mode == M_SERVICE);
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (PEND !== e.pend || MASK !== e.mask || NEXT_ID !== e.nid || NEXT_ON !== e.on ||
                    IRQ !== e.irq || ACTIVE_ID !== e.aid || IN_SERVICE !== e.ins) begin
                    failures++;
                    $display("FAIL snap t=%0t got pend=%h mask=%h nid=%0d on=%b irq=%b aid=%0d ins=%b want pend=%h mask=%h nid=%0d on=%b irq=%b aid=%0d ins=%b",
                             $time, PEND, MASK, NEXT_ID, NEXT_ON, IRQ, ACTIVE_ID, IN_SERVICE,
                             e.pend, e.mask, e.nid, e.on, e.irq, e.aid, e.ins);
                end
            end
        end
    end

    initial begin : driver
        logic [15:0] cur;
        RST = 1; SRC_TRIG = 0; MASK_WE = 0; MASK_WDATA = 0; ACK = 0; EOI = 0;
        step(1, 16'h0, 0, 16'h0, 0, 0);
        step(1, 16'h0, 0, 16'h0, 0, 0);

        // Single source: pulse, present, ack, eoi.
        step(0, 16'h0008, 0, 16'h0, 0, 0);
        idle(3);
        serve(4);

        // Same-cycle rises: NMI first, then lowest ID.
        step(0, 16'h0124, 0, 16'h0, 0, 0);
        idle(2);
        serve(12);

        // Mask all: only the NMI gets through until the mask opens bit 1.
        step(0, 16'h0, 1, 16'h0000, 0, 0);
        step(0, 16'h0102, 0, 16'h0, 0, 0);
        idle(3);
        step(0, 16'h0, 0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 16'h0002, 0, 0);
        idle(2);
        serve(8);
        step(0, 16'h0, 1, 16'hFFFF, 0, 0);

        // Higher-priority arrival during service of ID 4.
        step(0, 16'h0010, 0, 16'h0, 0, 0);
        idle(2);
        step(0, 16'h0, 0, 16'h0, 1, 0);
        step(0, 16'h0001, 0, 16'h0, 0, 0);
        idle(4);
        serve(8);

        // Nesting scenario (base build just serialises it).
        step(0, 16'h0040, 0, 16'h0, 0, 0);
        idle(2);
        step(0, 16'h0, 0, 16'h0, 1, 0);
        step(0, 16'h0004, 0, 16'h0, 0, 0);
        idle(3);
        step(0, 16'h0, 0, 16'h0, 1, 0);
        idle(1);
        serve(8);

        // Same-bit rise while that bit is acknowledged keeps it pending.
        step(0, 16'h0080, 0, 16'h0, 0, 0);
        step(0, 16'h0000, 0, 16'h0, 0, 0);
        idle(1);
        step(0, 16'h0080, 0, 16'h0, 1, 0);
        step(0, 16'h0000, 0, 16'h0, 0, 1);
        serve(8);

        // Reset while presenting with PEND=0x0011.
        step(0, 16'h0011, 0, 16'h0, 0, 0);
        idle(2);
        step(1, 16'h0, 0, 16'h0, 0, 0);
        idle(4);

        // Randomised traffic.
        cur = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            logic r, mw, a, e;
            logic [15:0] md;
            if ($urandom_range(0, 2) == 0) cur = cur ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            r  = ($urandom_range(0, 299) == 0);
            mw = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0: md = 16'h0000;
                1: md = 16'hFFFF;
                default: md = 16'($urandom);
            endcase
            a = (m_mode == M_PRESENT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            e = (m_mode == M_SERVICE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            step(r, cur, mw, md, a, e);
        end
        idle(3);

        repeat (2) @(posedge CLK);
        #3;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending snapshots want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
